// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC width, and the halt opcode
// encoding that the decoder uses to raise the fetch unit's halt input.
package cpu_pkg;

  localparam int PC_W = 12;

  localparam logic [8:0] HALT_OPCODE = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Control, branch and status bundle between the sequencing logic (master)
// and the fetch unit (slave).
interface fetch_unit_if #(
  parameter int D    = 12,
  parameter int OFFW = 8,
  parameter int CW   = 16
);
  logic            start;
  logic            stall;
  logic            branchTaken;
  logic            branchRelative;
  logic [D-1:0]    branchTarget;
  logic [OFFW-1:0] branchOffset;
  logic            halt;
  logic [D-1:0]    programCounter;
  logic            fetchValid;
  logic            done;
  logic            pcOverflow;
  logic [CW-1:0]   cycleCount;

  modport master (
    output start, stall, branchTaken, branchRelative, branchTarget,
           branchOffset, halt,
    input  programCounter, fetchValid, done, pcOverflow, cycleCount
  );

  modport slave (
    input  start, stall, branchTaken, branchRelative, branchTarget,
           branchOffset, halt,
    output programCounter, fetchValid, done, pcOverflow, cycleCount
  );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-address mux: sequential increment, absolute target,
// or PC plus sign-extended offset (wrapping modulo 2**D). Also flags a
// sequential advance from the last address.
module pc_next #(
  parameter int D    = 12,
  parameter int OFFW = 8
) (
  input  logic [D-1:0]    i_pc,
  input  logic            i_branch,
  input  logic            i_relative,
  input  logic [D-1:0]    i_target,
  input  logic [OFFW-1:0] i_offset,
  output logic [D-1:0]    o_next_pc,
  output logic            o_seq_ovf
);

  logic signed [D-1:0] w_off_ext;

  assign w_off_ext = D'($signed(i_offset));

  // Select the candidate next address; addition wraps naturally at D bits.
  always_comb begin
    o_next_pc = i_pc + D'(1);
    if (i_branch) begin
      if (i_relative) o_next_pc = i_pc + D'(w_off_ext);
      else            o_next_pc = i_target;
    end
  end

  assign o_seq_ovf = &i_pc;

endmodule

// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencing stage. Turns a start pulse into a
// run from address 0, advances sequentially or by branch, stalls on
// request and stops on halt or on running off the last address.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int D    = PC_W,
  parameter int OFFW = 8,
  parameter int CW   = 16
) (
  input  logic         clk,
  input  logic         resetN,
  fetch_unit_if.slave  bus
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [D-1:0]  r_pc;
  logic [D-1:0]  w_pc_d;
  logic [D-1:0]  w_pc_mux;
  logic          w_seq_ovf;
  logic          w_ovf_set;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;

  pc_next #(
    .D    (D),
    .OFFW (OFFW)
  ) u_pc_next (
    .i_pc       (r_pc),
    .i_branch   (bus.branchTaken),
    .i_relative (bus.branchRelative),
    .i_target   (bus.branchTarget),
    .i_offset   (bus.branchOffset),
    .o_next_pc  (w_pc_mux),
    .o_seq_ovf  (w_seq_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next state, next PC and overflow event; halt > stall > branch > increment.
  always_comb begin
    w_next_state = r_state;
    w_pc_d       = r_pc;
    w_ovf_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = ARMED;
      end
      ARMED: begin
        if (!bus.start) w_next_state = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          w_next_state = DONE;
        end else if (bus.stall) begin
          w_pc_d = r_pc;
        end else if (bus.branchTaken) begin
          w_pc_d = w_pc_mux;
        end else if (w_seq_ovf) begin
          w_next_state = DONE;
          w_ovf_set    = 1'b1;
        end else begin
          w_pc_d = w_pc_mux;
        end
      end
      DONE: begin
        if (bus.start) w_next_state = ARMED;
      end
      default: w_next_state = IDLE;
    endcase
    // Entering or sitting in ARMED parks the PC at the first instruction.
    if (w_next_state == ARMED) w_pc_d = '0;
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (!resetN) r_pc <= '0;
    else         r_pc <= w_pc_d;
  end

  // Sticky overflow flag, cleared when a new run is armed.
  always_ff @(posedge clk) begin
    if (!resetN)                    r_ovf <= 1'b0;
    else if (w_next_state == ARMED) r_ovf <= 1'b0;
    else if (w_ovf_set)             r_ovf <= 1'b1;
  end

  // Saturating RUN-cycle counter, cleared when a new run is armed.
  always_ff @(posedge clk) begin
    if (!resetN)                            r_cnt <= '0;
    else if (w_next_state == ARMED)         r_cnt <= '0;
    else if (r_state == RUN && r_cnt != '1) r_cnt <= r_cnt + CW'(1);
  end

  assign bus.programCounter = r_pc;
  assign bus.fetchValid     = (r_state == RUN);
  assign bus.done           = (r_state == DONE);
  assign bus.pcOverflow     = r_ovf;
  assign bus.cycleCount     = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, arming, sequential fetch, branches
// with wrap, stall, halt, end-of-memory overflow and counter saturation.
module tb_fetch_unit;

  localparam int D    = 12;
  localparam int OFFW = 8;
  localparam int CW   = 16;

  logic clk;
  logic resetN;

  int n_checks;
  int n_fail;

  fetch_unit_if #(.D(D), .OFFW(OFFW), .CW(CW)) bus ();

  fetch_unit #(.D(D), .OFFW(OFFW), .CW(CW)) u_dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_branch();
    bus.branchTaken    = 1'b0;
    bus.branchRelative = 1'b0;
    bus.branchTarget   = '0;
    bus.branchOffset   = '0;
  endtask

  task automatic check_all(input string tag, input logic [11:0] pc,
                           input logic fv, input logic dn, input logic ov,
                           input logic [15:0] cnt);
    check_val({tag, ".pc"},   32'(bus.programCounter), 32'(pc));
    check_val({tag, ".fv"},   32'(bus.fetchValid),     32'(fv));
    check_val({tag, ".done"}, 32'(bus.done),           32'(dn));
    check_val({tag, ".ovf"},  32'(bus.pcOverflow),     32'(ov));
    check_val({tag, ".cnt"},  32'(bus.cycleCount),     32'(cnt));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    resetN     = 1'b0;
    bus.start  = 1'b0;
    bus.stall  = 1'b0;
    bus.halt   = 1'b0;
    clr_branch();

    // Reset values
    tick(2);
    check_all("rst", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);

    // start held 3 cycles: ARMED keeps PC at 0
    resetN    = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("armed", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    end
    bus.start = 1'b0;
    tick();
    check_all("run0", 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_all("run1", 12'h001, 1'b1, 1'b0, 1'b0, 16'd1);
    tick();
    check_all("run2", 12'h002, 1'b1, 1'b0, 1'b0, 16'd2);
    tick();
    check_all("run3", 12'h003, 1'b1, 1'b0, 1'b0, 16'd3);

    // Reset mid-run at PC 0x01A, count 26
    tick(23);
    check_all("pre_rst", 12'h01A, 1'b1, 1'b0, 1'b0, 16'd26);
    resetN = 1'b0;
    tick();
    check_all("mid_rst", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    resetN = 1'b1;
    tick();
    check_all("idle", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);

    // Single-cycle start pulse, run from 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_all("rerun0", 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
    tick(5);
    check_val("pc5", 32'(bus.programCounter), 32'h005);

    // Relative -6 from 0x005 wraps to 0xFFF
    bus.branchTaken    = 1'b1;
    bus.branchRelative = 1'b1;
    bus.branchOffset   = 8'hFA;
    tick();
    check_val("rel_m6", 32'(bus.programCounter), 32'hFFF);
    // Relative +2 from 0xFFF wraps to 0x001
    bus.branchOffset = 8'h02;
    tick();
    check_val("rel_p2", 32'(bus.programCounter), 32'h001);
    clr_branch();
    tick(6);
    check_all("pc7", 12'h007, 1'b1, 1'b0, 1'b0, 16'd13);

    // Stall 2 cycles at 0x007, branch during stall ignored
    bus.stall        = 1'b1;
    bus.branchTaken  = 1'b1;
    bus.branchTarget = 12'h300;
    tick();
    check_all("stall1", 12'h007, 1'b1, 1'b0, 1'b0, 16'd14);
    tick();
    check_all("stall2", 12'h007, 1'b1, 1'b0, 1'b0, 16'd15);
    bus.stall = 1'b0;
    clr_branch();
    tick();
    check_all("unstall", 12'h008, 1'b1, 1'b0, 1'b0, 16'd16);

    // Absolute branch 0x010 -> 0x200
    tick(8);
    check_val("pc10", 32'(bus.programCounter), 32'h010);
    bus.branchTaken  = 1'b1;
    bus.branchTarget = 12'h200;
    tick();
    check_val("abs200", 32'(bus.programCounter), 32'h200);
    bus.branchTarget = 12'h030;
    tick();
    check_val("abs030", 32'(bus.programCounter), 32'h030);

    // Halt with branch at 0x030: halt wins
    bus.halt         = 1'b1;
    bus.branchTarget = 12'h100;
    tick();
    check_all("halt", 12'h030, 1'b0, 1'b1, 1'b0, 16'd27);
    bus.halt = 1'b0;
    clr_branch();
    tick();
    check_all("done_hold", 12'h030, 1'b0, 1'b1, 1'b0, 16'd27);

    // New start from DONE clears done and count
    bus.start = 1'b1;
    tick();
    check_all("rearm", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b0;
    tick();
    check_all("rerun", 12'h000, 1'b1, 1'b0, 1'b0, 16'd0);

    // Branch to 0xFFE, then fall off the end
    bus.branchTaken  = 1'b1;
    bus.branchTarget = 12'hFFE;
    tick();
    check_val("absFFE", 32'(bus.programCounter), 32'hFFE);
    clr_branch();
    tick();
    check_all("pcFFF", 12'hFFF, 1'b1, 1'b0, 1'b0, 16'd2);
    tick();
    check_all("ovf", 12'hFFF, 1'b0, 1'b1, 1'b1, 16'd3);
    tick();
    check_all("ovf_hold", 12'hFFF, 1'b0, 1'b1, 1'b1, 16'd3);

    // Restart clears overflow; relative -1 from 0 wraps to 0xFFF
    bus.start = 1'b1;
    tick();
    check_all("rearm2", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b0;
    tick();
    bus.branchTaken    = 1'b1;
    bus.branchRelative = 1'b1;
    bus.branchOffset   = 8'hFF;
    tick();
    check_val("rel_m1", 32'(bus.programCounter), 32'hFFF);
    clr_branch();

    // start during RUN ignored
    bus.stall = 1'b1;
    bus.start = 1'b1;
    tick();
    check_all("start_run", 12'hFFF, 1'b1, 1'b0, 1'b0, 16'd2);
    bus.start = 1'b0;

    // Counter saturation while stalled
    tick(65540);
    check_all("sat", 12'hFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    bus.stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
